// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register family.
// The state encoding is one flop per handshake output: bit 1 = in_ready, bit 0 = out_valid.
package pipe_pkg;

    localparam int PIPE_STALL_CNT_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'b10,
        BUSY  = 2'b11,
        FULL  = 2'b01
    } pipe_state_t;

endpackage

// File: rtl/pipe_stall_cnt.sv
// Saturating up-counter with enable and asynchronous active-high clear.
module pipe_stall_cnt
    import pipe_pkg::*;
#(
    parameter int W = PIPE_STALL_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// Optional stall-cycle counter is built when PIPE_STATS_EN is defined.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
`ifdef PIPE_STATS_EN
    output logic [PIPE_STALL_CNT_W-1:0] stall_cnt,
`endif
    output logic [1:0]               state_dbg
);

    // Handshake: a beat moves on a rising edge only when valid and ready are both
    // high in the preceding cycle; valid never waits on ready, and ready is a flop.
    pipe_state_t state_q, state_d;
    logic [LANES*WIDTH-1:0] main_q, main_d;
    logic [LANES*WIDTH-1:0] skid_q, skid_d;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        state_d = BUSY;
                        main_d  = in_data;
                    end
                end
                BUSY: begin
                    if (in_valid && out_ready) begin
                        main_d = in_data;
                    end else if (in_valid) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Both handshake outputs are state bits, so no path from out_ready to in_ready.
    assign in_ready  = state_q[1];
    assign out_valid = state_q[0];
    assign out_data  = main_q;
    assign state_dbg = state_q;

`ifdef PIPE_STATS_EN
    pipe_stall_cnt #(
        .W(PIPE_STALL_CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .en_i (out_valid & ~out_ready),
        .cnt_o(stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg against a queue-based reference model.
// Stall-counter checks are built when PIPE_STATS_EN is defined.
module tb_pipe_skid_reg;

    localparam int WIDTH = 32;
    localparam int LANES = 2;
    localparam int DW    = WIDTH * LANES;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    state_dbg;
`ifdef PIPE_STATS_EN
    logic [31:0]   stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    logic [31:0]   exp_stall;

    pipe_skid_reg #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
`ifdef PIPE_STATS_EN
        .stall_cnt(stall_cnt),
`endif
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pair(input logic [31:0] l1, input logic [31:0] l0);
        return {l1, l0};
    endfunction

    // Reference: the stage is a FIFO of at most two beats; ready means fewer than two held.
    task automatic model_edge();
        bit pop, push;
        pop  = (exp_q.size() > 0) && out_ready;
        push = in_valid && (exp_q.size() < 2);
        if ((exp_q.size() > 0) && !out_ready && (exp_stall != 32'hFFFF_FFFF)) exp_stall++;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back(in_data);
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_stall = '0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
`ifdef PIPE_STATS_EN
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = pair(32'hA + i, 32'h1 + i);
            cycle();
            checks++; if (out_valid !== 1'b1 || out_data !== pair(32'hA + i, 32'h1 + i)) begin
                failures++; $display("FAIL stream_beat%0d got=%0b/%h exp=1/%h", i, out_valid, out_data, pair(32'hA + i, 32'h1 + i));
            end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready%0d got=%0b exp=1", i, in_ready); end
        end
        in_valid = 1'b0;
        cycle();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_stall_skid();
        out_ready = 1'b1; in_valid = 1'b1; in_data = pair(32'h10, 32'h10);
        cycle();
        out_ready = 1'b0; in_data = pair(32'h11, 32'h11);
        cycle();
        checks++; if (out_data !== pair(32'h10, 32'h10) || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++; $display("FAIL stall_full got=%h rdy=%0b vld=%0b exp=%h rdy=0 vld=1", out_data, in_ready, out_valid, pair(32'h10, 32'h10));
        end
        in_data = pair(32'h12, 32'h12);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (out_data !== pair(32'h10, 32'h10) || in_ready !== 1'b0) begin
                failures++; $display("FAIL stall_hold%0d got=%h rdy=%0b exp=%h rdy=0", i, out_data, in_ready, pair(32'h10, 32'h10));
            end
        end
`ifdef PIPE_STATS_EN
        checks++; if (stall_cnt !== 32'd4) begin failures++; $display("FAIL stall_count got=%0d exp=4", stall_cnt); end
`endif
        out_ready = 1'b1;
        cycle();
        checks++; if (out_data !== pair(32'h11, 32'h11) || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            failures++; $display("FAIL stall_drain1 got=%h rdy=%0b exp=%h rdy=1", out_data, in_ready, pair(32'h11, 32'h11));
        end
        cycle();
        in_valid = 1'b0;
        checks++; if (out_data !== pair(32'h12, 32'h12) || out_valid !== 1'b1) begin
            failures++; $display("FAIL stall_drain2 got=%h exp=%h", out_data, pair(32'h12, 32'h12));
        end
        cycle();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_empty got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = pair(32'h20, 32'h20); cycle();
        in_data = pair(32'h21, 32'h21); cycle();
        flush = 1'b1; in_data = pair(32'h22, 32'h22); cycle();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_state vld=%0b rdy=%0b exp vld=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_quiet%0d got=%0b exp=0", i, out_valid); end
        end
        in_valid = 1'b1; in_data = pair(32'h23, 32'h23); cycle();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== pair(32'h23, 32'h23)) begin
            failures++; $display("FAIL flush_next got=%0b/%h exp=1/%h", out_valid, out_data, pair(32'h23, 32'h23));
        end
        cycle();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = pair(32'h30, 32'h31); cycle();
        in_data = pair(32'h32, 32'h33); cycle();
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            failures++; $display("FAIL async_rst vld=%0b rdy=%0b data=%h exp vld=0 rdy=1 data=0", out_valid, in_ready, out_data);
        end
`ifdef PIPE_STATS_EN
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL async_rst_cnt got=%0d exp=0", stall_cnt); end
`endif
        exp_q.delete();
        exp_stall = '0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_data   = {$urandom(), $urandom()};
            cycle();
            checks++; if (out_valid !== (exp_q.size() > 0)) begin
                failures++; $display("FAIL rand_valid n=%0d got=%0b exp=%0b", n, out_valid, exp_q.size() > 0);
            end
            checks++; if (in_ready !== (exp_q.size() < 2)) begin
                failures++; $display("FAIL rand_ready n=%0d got=%0b exp=%0b", n, in_ready, exp_q.size() < 2);
            end
            if (exp_q.size() > 0) begin
                checks++; if (out_data !== exp_q[0]) begin
                    failures++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, out_data, exp_q[0]);
                end
            end
`ifdef PIPE_STATS_EN
            checks++; if (stall_cnt !== exp_stall) begin
                failures++; $display("FAIL rand_stall n=%0d got=%0d exp=%0d", n, stall_cnt, exp_stall);
            end
`endif
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
    endtask

`ifdef PIPE_STATS_EN
    task automatic test_saturation();
        out_ready = 1'b0; in_valid = 1'b1; in_data = pair(32'h40, 32'h41);
        cycle();
        in_valid = 1'b0;
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFD;
        #1 release dut.u_stall_cnt.cnt_q;
        exp_stall = 32'hFFFF_FFFD;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++; if (stall_cnt !== exp_stall) begin
                failures++; $display("FAIL sat_step%0d got=%h exp=%h", i, stall_cnt, exp_stall);
            end
        end
        checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL sat_hold got=%h exp=ffffffff", stall_cnt);
        end
        out_ready = 1'b1;
        cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush_full();
        test_async_reset();
        test_random();
`ifdef PIPE_STATS_EN
        test_saturation();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It carries `LANES` independent data fields of `WIDTH` bits each between adjacent stages of the RV32I pipeline, for example EX/MEM or MEM/WB. Compared with a plain stage register, it adds:
- back-pressure (stall) without a combinational ready path,
- a synchronous flush for branch/exception squash,
- an optional stall-cycle counter.

## Interface
- `WIDTH`, 32, bits per data lane
- `LANES`, 2, number of lanes (for example ALU result and load data)
- `clk` input 1: clock, rising-edge
- `rst` input 1: asynchronous, active-high reset
- `flush` input 1: synchronous squash of all held entries
- `in_valid` input 1: upstream presents data
- `in_ready` output 1: stage can accept; driven directly from a flop
- `in_data` input LANES*WIDTH: lane k occupies bits [k*WIDTH +: WIDTH]
- `out_valid` output 1: downstream data valid
- `out_ready` input 1: downstream accepts
- `out_data` output LANES*WIDTH: same lane packing as `in_data`
- `stall_cnt` output 32: present only with `PIPE_STATS_EN`

## Operation
- Storage:
  - main register `main_q` drives `out_data`.
  - skid register `skid_q` holds an overflow beat.
  - Both are LANES*WIDTH bits.
- Transfers:
  - Input transfer = `in_valid & in_ready`.
  - Output transfer = `out_valid & out_ready`.
- States:
  - EMPTY: `out_valid=0`, `in_ready=1`.
  - BUSY: `out_valid=1`, `in_ready=1`.
  - FULL: `out_valid=1`, `in_ready=0`.
- Transitions (if `flush` is not asserted):
  - EMPTY: `in_valid` → BUSY, `main_q<=in_data`; otherwise stay.
  - BUSY with `in_valid & out_ready` → BUSY, `main_q<=in_data`.
  - BUSY with `in_valid & !out_ready` → FULL, `skid_q<=in_data`.
  - BUSY with `!in_valid & out_ready` → EMPTY.
  - BUSY with `!in_valid & !out_ready` → hold.
  - FULL with `out_ready` → BUSY, `main_q<=skid_q`. `in_data` is ignored because `in_ready=0`.
  - FULL with `!out_ready` → hold.
- Flush:
  - Highest priority. Next state is EMPTY regardless of handshakes.
  - Any input transfer in the flush cycle is discarded.
  - `main_q`/`skid_q` contents are retained, but both are invalid.
- Reset: state EMPTY, `main_q=0`, `skid_q=0`, `out_data=0`, `out_valid=0`, `in_ready=1`, `stall_cnt=0`.
- Order and width:
  - Data is never reordered, duplicated or dropped, except on flush.
  - No width conversion; lanes pass through bit-exact.

## Timing
- Latency: an input transfer at edge N gives `out_valid` and the data from edge N, visible after that edge.
- Throughput: one beat per cycle while `out_ready=1`.
- Under stall:
  - `in_ready` falls one cycle after the stall begins, once the skid entry is occupied.
  - It rises the cycle after the FULL→BUSY drain.
- `in_ready` and `out_valid` are pure flop outputs; no combinational path from `out_ready` to `in_ready`.
- `out_data` is stable while `out_valid & !out_ready`.
- `rst` asserted mid-transfer discards all held beats immediately (asynchronous).

## Configuration
- `PIPE_STATS_EN` defined:
  - Port `stall_cnt` exists.
  - It increments every cycle with `out_valid & !out_ready`.
  - It saturates at 32'hFFFF_FFFF.
  - It is cleared only by `rst`; `flush` does not affect it.
- `PIPE_STATS_EN` undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum typedef `pipe_state_t` (EMPTY, BUSY, FULL);
  - the constant `PIPE_STALL_CNT_W = 32`.
- One sub-module, `pipe_stall_cnt`: saturating counter with enable, instantiated only under `PIPE_STATS_EN`.
- Datapath muxes and the FSM stay in `pipe_skid_reg`.

## Test plan
- Reset release:
  - Stimulus: hold `rst` high, then release.
  - Response: `out_valid=0`, `in_ready=1`, `out_data=0`, `stall_cnt=0` (when `PIPE_STATS_EN` is defined).
- Streaming:
  - Stimulus: `out_ready=1`; drive `in_data` = 0x1/0x2/0x3 (lane0) and 0xA/0xB/0xC (lane1) on consecutive cycles.
  - Response: same pairs on `out_data`, each one cycle later, no bubbles.
- Stall with skid:
  - Stimulus: beats 0x10, 0x11, 0x12 offered back-to-back; `out_ready=0` from the cycle 0x10 appears on `out_data`.
  - Response:
    - 0x10 held on `out_data`, 0x11 captured in the skid register.
    - `in_ready=0`; 0x12 is held by upstream, not lost.
    - Releasing `out_ready` delivers 0x10, 0x11, 0x12 in order.
    - `stall_cnt` equals the number of stalled cycles.
- Flush in FULL:
  - Stimulus: FULL state, `flush=1` for one cycle with `in_valid=1`.
  - Response: next cycle `out_valid=0`, `in_ready=1`; neither held beat nor the flush-cycle input ever appears on the output.
- Asynchronous reset mid-stall:
  - Stimulus: assert `rst` between clock edges while FULL.
  - Response: `out_valid` drops immediately, `out_data=0`, `stall_cnt=0`.
- Counter saturation (`PIPE_STATS_EN` defined):
  - Stimulus: preload `stall_cnt` near 32'hFFFF_FFFF via force, then stall.
  - Response: counter holds at 32'hFFFF_FFFF.
